tohost_monitor: RTL and testbench
=================================

Name: tohost_monitor

Overview:
- Synthesizable successor to the simulation-only tohost check. It snoops the CPU data-memory write bus and decides pass, fail or timeout using the riscv-tests tohost convention.
- It also captures console bytes written to a second address into a parametrised FIFO, drained by a valid/ready handshake.
- It sits beside dmem in top and lets on-board and simulation runs report status without $stop.

Parameters:
- ADDR_W, 32, width of the data-memory address bus
- DATA_W, 32, width of the write data bus; must be ≥ 8
- BE_W, DATA_W/8, width of the byte-enable bus
- TOHOST_ADDR, 32'h0000_1000, address that ends the test
- CONSOLE_ADDR, 32'h0000_1004, address whose low byte is pushed to the console FIFO
- TIMEOUT_CYCLES, 100000, cycle limit while running; 0 disables the timeout
- CNT_W, 32, width of the cycle counter
- CON_DEPTH, 16, console FIFO depth; power of two, ≥ 2

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  reset, synchronous, active-high
- mem_we  in  BE_W  dmem byte write enables; a write occurs when any bit is set
- mem_addr  in  ADDR_W  dmem address
- mem_wdata  in  DATA_W  dmem write data
- status  out  2  0 = RUNNING, 1 = PASS, 2 = FAIL, 3 = TIMEOUT
- done  out  1  high when status != RUNNING
- fail_code  out  DATA_W-1  mem_wdata >> 1, captured on a FAIL write
- cycle_count  out  CNT_W  cycles spent in RUNNING
- con_valid  out  1  FIFO head valid
- con_data  out  8  FIFO head byte
- con_ready  in  1  consumer accepts the head byte
- con_overflow  out  1  sticky: a console push was dropped

Behaviour:
- Reset (sys_rst high at a sys_clk edge) sets:
  - status = 0, done = 0, fail_code = 0, cycle_count = 0
  - FIFO emptied, con_valid = 0, con_data = 0, con_overflow = 0
- Reset has priority over every other event, including mid-operation and the same cycle as a write or pop.
- All outputs are registered. No combinational path exists from inputs to outputs.

Status state machine:
- From RUNNING:
  - Tohost write (|mem_we && mem_addr == TOHOST_ADDR) with mem_wdata == 1 → PASS.
  - Tohost write with any other value, including 0 → FAIL, and fail_code <= mem_wdata[DATA_W-1:1].
  - Otherwise, if TIMEOUT_CYCLES != 0 and cycle_count == TIMEOUT_CYCLES-1 → TIMEOUT.
- A tohost write and timeout expiry in the same cycle: the write wins.
- PASS, FAIL and TIMEOUT are terminal until reset. Later tohost writes change nothing.
- status, done and fail_code update one cycle after the write's sampling edge (latency 1).
- The tohost value is taken from the full mem_wdata regardless of which byte enables are set.

cycle_count:
- Increments every cycle while status == RUNNING; it counts the cycle of the terminating write.
- Frozen while done == 1.
- Saturates at all-ones and never wraps.

Console FIFO:
- Push when |mem_we && mem_we[0] && mem_addr == CONSOLE_ADDR. Data is mem_wdata[7:0].
- Pushes are accepted in any status, including after done.
- Pop when con_valid && con_ready.
- con_valid and con_data are registered from FIFO storage. A push into an empty FIFO makes con_valid high on the next cycle; there is no fall-through.
- con_data holds its last value when empty.
- When full, a push is accepted only if a pop happens in the same cycle (occupancy unchanged). Otherwise the push is dropped and con_overflow is set; it stays set until reset.
- Push and pop in the same cycle on a non-empty, non-full FIFO: occupancy unchanged, order preserved.
- Pointers are log2(CON_DEPTH) bits plus one wrap bit. Wrap-around is seamless.
- A write to an address other than TOHOST_ADDR or CONSOLE_ADDR has no effect.

Test Plan:
- Reset, then idle 10 cycles → status = 0, cycle_count = 10. Then write 1 to 0x1000 with mem_we = 4'hF → next cycle status = 1, done = 1; cycle_count = 11 and stays frozen for 20 more cycles.
- Write 0x0000_0007 to 0x1000 → status = 2, fail_code = 3. A later write of 1 to 0x1000 → status stays 2.
- TIMEOUT_CYCLES = 50, no writes → status = 3 on the cycle after cycle_count reaches 49. Rerun with a tohost write of 1 on the expiry cycle → status = 1.
- CON_DEPTH = 4: push 'A','B','C','D','E' with con_ready = 0 → con_overflow = 1. Then con_ready = 1 → pops A, B, C, D in order, after which con_valid = 0.
- Full FIFO, push 'X' with con_ready = 1 in the same cycle → no overflow; head advances and X is delivered last. Push into empty FIFO → con_valid = 0 that cycle, 1 the next.
- Assert sys_rst mid-run with a pending tohost write in the same cycle → all outputs zero next cycle and the write is ignored. Wait 1 cycle, then write 0 to 0x1000 with mem_we = 4'h1 → status = 2, fail_code = 0.

Source files
------------

// File: rtl/tohost_monitor.sv
// Snoops the dmem write bus: decides pass/fail/timeout from tohost writes and
// buffers console bytes in a small FIFO drained with a valid/ready handshake.
module tohost_monitor #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                BE_W           = DATA_W / 8,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_1000),
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = ADDR_W'(32'h0000_1004),
    parameter int                TIMEOUT_CYCLES = 100000,
    parameter int                CNT_W          = 32,
    parameter int                CON_DEPTH      = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [BE_W-1:0]   mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        status,
    output logic              done,
    output logic [DATA_W-2:0] fail_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              con_valid,
    output logic [7:0]        con_data,
    input  logic              con_ready,
    output logic              con_overflow
);

    typedef enum logic [1:0] {
        ST_RUNNING = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_e;

    localparam int               PTR_W        = $clog2(CON_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    status_e             status_q, status_d;
    logic                done_q, done_d;
    logic [DATA_W-2:0]   fail_code_q, fail_code_d;
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
    logic                con_valid_q, con_valid_d;
    logic [7:0]          con_data_q, con_data_d;
    logic                con_overflow_q, con_overflow_d;
    logic [7:0]          fifo_q [CON_DEPTH];

    logic tohost_wr, con_push, fifo_full, pop, push_acc;

    assign tohost_wr = (|mem_we) && (mem_addr == TOHOST_ADDR);
    assign con_push  = mem_we[0] && (mem_addr == CONSOLE_ADDR);
    assign fifo_full = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop       = con_valid_q && con_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_acc  = con_push && (!fifo_full || pop);

    always_comb begin
        status_d      = status_q;
        fail_code_d   = fail_code_q;
        cycle_count_d = cycle_count_q;
        if (status_q == ST_RUNNING) begin
            if (cycle_count_q != CNT_MAX) cycle_count_d = cycle_count_q + 1'b1;
            if (tohost_wr) begin
                if (mem_wdata == DATA_W'(1)) begin
                    status_d = ST_PASS;
                end else begin
                    status_d    = ST_FAIL;
                    fail_code_d = mem_wdata[DATA_W-1:1];
                end
            end else if (TIMEOUT_EN && cycle_count_q == TIMEOUT_LAST) begin
                status_d = ST_TIMEOUT;
            end
        end
        done_d = (status_d != ST_RUNNING);
    end

    always_comb begin
        wr_ptr_d       = wr_ptr_q + {{PTR_W{1'b0}}, push_acc};
        rd_ptr_d       = rd_ptr_q + {{PTR_W{1'b0}}, pop};
        con_overflow_d = con_overflow_q | (con_push && !push_acc);
        con_valid_d    = (wr_ptr_d != rd_ptr_d);
        con_data_d     = con_data_q;
        // The next head may be the byte being written this very cycle.
        if (con_valid_d) begin
            if (push_acc && rd_ptr_d == wr_ptr_q) con_data_d = mem_wdata[7:0];
            else                                  con_data_d = fifo_q[rd_ptr_d[PTR_W-1:0]];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            status_q       <= ST_RUNNING;
            done_q         <= 1'b0;
            fail_code_q    <= '0;
            cycle_count_q  <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            con_valid_q    <= 1'b0;
            con_data_q     <= '0;
            con_overflow_q <= 1'b0;
        end else begin
            status_q       <= status_d;
            done_q         <= done_d;
            fail_code_q    <= fail_code_d;
            cycle_count_q  <= cycle_count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            con_valid_q    <= con_valid_d;
            con_data_q     <= con_data_d;
            con_overflow_q <= con_overflow_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst && push_acc) fifo_q[wr_ptr_q[PTR_W-1:0]] <= mem_wdata[7:0];
    end

    assign status       = status_q;
    assign done         = done_q;
    assign fail_code    = fail_code_q;
    assign cycle_count  = cycle_count_q;
    assign con_valid    = con_valid_q;
    assign con_data     = con_data_q;
    assign con_overflow = con_overflow_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor: directed scenarios plus random bus traffic checked
// against a queue-based reference model and a console-byte scoreboard.
module tb_tohost_monitor;

    localparam int TIMEOUT = 50;
    localparam int DEPTH   = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  mem_we = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        con_ready = 1'b0;
    logic [1:0]  status;
    logic        done;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_overflow;

    tohost_monitor #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .CON_DEPTH     (DEPTH)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .status      (status),
        .done        (done),
        .fail_code   (fail_code),
        .cycle_count (cycle_count),
        .con_valid   (con_valid),
        .con_data    (con_data),
        .con_ready   (con_ready),
        .con_overflow(con_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: bytes accepted but not yet delivered, plus test verdict.
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          m_status = 0;
    longint      m_cycles = 0;
    logic [30:0] m_fail = '0;
    bit          m_ovf = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_status = 0;
            m_cycles = 0;
            m_fail   = '0;
            m_ovf    = 1'b0;
            exp_q.delete();
        end else begin
            if (m_status == 0) begin
                if (m_cycles < 64'h0000_0000_FFFF_FFFF) m_cycles++;
                if (mem_we != 0 && mem_addr == 32'h0000_1000) begin
                    if (mem_wdata == 32'd1) begin
                        m_status = 1;
                    end else begin
                        m_status = 2;
                        m_fail   = 31'(mem_wdata >> 1);
                    end
                end else if (m_cycles == TIMEOUT) begin
                    m_status = 3;
                end
            end
            if (exp_q.size() > 0 && con_ready) void'(exp_q.pop_front());
            if (mem_we[0] && mem_addr == 32'h0000_1004) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(mem_wdata[7:0]);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("status", 64'(status), 64'(m_status));
            check("done", 64'(done), 64'(m_status != 0));
            check("fail_code", 64'(fail_code), 64'(m_fail));
            check("cycle_count", 64'(cycle_count), 64'(m_cycles));
            check("con_overflow", 64'(con_overflow), 64'(m_ovf));
            check("con_valid", 64'(con_valid), 64'(exp_q.size() > 0));
            if (con_valid && exp_q.size() > 0) check("con_data", 64'(con_data), 64'(exp_q[0]));
            if (con_valid && con_ready) got_q.push_back(con_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
        mem_addr  = addr;
        mem_wdata = data;
        mem_we    = we;
        tick(1);
        mem_we    = '0;
    endtask

    task automatic check_got(input string name, input string s);
        check({name, "_len"}, 64'(got_q.size()), 64'(s.len()));
        for (int i = 0; i < s.len() && i < got_q.size(); i++)
            check(name, 64'(got_q[i]), 64'(s[i]));
    endtask

    initial begin
        string abcde;
        abcde = "ABCDE";
        tick(2);
        sys_rst = 1'b0;
        chk_en  = 1'b1;
        check("rst_status", 64'(status), 64'd0);
        check("rst_con_data", 64'(con_data), 64'd0);
        check("rst_valid", 64'(con_valid), 64'd0);

        // Pass after idle, counter freezes.
        tick(10);
        check("idle_cnt", 64'(cycle_count), 64'd10);
        do_write(32'h1000, 32'd1, 4'hF);
        check("pass_status", 64'(status), 64'd1);
        check("pass_done", 64'(done), 64'd1);
        check("pass_cnt", 64'(cycle_count), 64'd11);
        tick(20);
        check("frozen_cnt", 64'(cycle_count), 64'd11);

        // Fail code capture, terminal state.
        do_reset();
        do_write(32'h1000, 32'd7, 4'hF);
        check("fail_status", 64'(status), 64'd2);
        check("fail_code7", 64'(fail_code), 64'd3);
        do_write(32'h1000, 32'd1, 4'hF);
        check("fail_sticky", 64'(status), 64'd2);

        // Timeout, and write winning on the expiry cycle.
        do_reset();
        tick(TIMEOUT - 1);
        check("pre_to_status", 64'(status), 64'd0);
        check("pre_to_cnt", 64'(cycle_count), 64'(TIMEOUT - 1));
        tick(1);
        check("to_status", 64'(status), 64'd3);
        do_reset();
        tick(TIMEOUT - 1);
        do_write(32'h1000, 32'd1, 4'hF);
        check("to_race_status", 64'(status), 64'd1);

        // Overflow, then in-order drain.
        do_reset();
        con_ready = 1'b0;
        for (int i = 0; i < 5; i++) do_write(32'h1004, 32'(abcde[i]), 4'h1);
        check("ovf_set", 64'(con_overflow), 64'd1);
        got_q.delete();
        con_ready = 1'b1;
        tick(4);
        con_ready = 1'b0;
        check("drain_empty", 64'(con_valid), 64'd0);
        check_got("drain_order", "ABCD");

        // Push on full with simultaneous pop.
        do_reset();
        do_write(32'h1004, 32'h50, 4'h1);
        do_write(32'h1004, 32'h51, 4'h1);
        do_write(32'h1004, 32'h52, 4'h1);
        do_write(32'h1004, 32'h53, 4'h1);
        got_q.delete();
        con_ready = 1'b1;
        do_write(32'h1004, 32'h58, 4'h1);
        check("full_push_ovf", 64'(con_overflow), 64'd0);
        tick(4);
        con_ready = 1'b0;
        check_got("full_push_order", "PQRSX");
        mem_addr  = 32'h1004;
        mem_wdata = 32'h5A;
        mem_we    = 4'h1;
        check("empty_push_now", 64'(con_valid), 64'd0);
        tick(1);
        mem_we    = '0;
        check("empty_push_next", 64'(con_valid), 64'd1);
        check("empty_push_data", 64'(con_data), 64'h5A);

        // Reset beats a same-cycle tohost write.
        do_write(32'h1000, 32'd5, 4'hF);
        sys_rst   = 1'b1;
        mem_addr  = 32'h1000;
        mem_wdata = 32'd7;
        mem_we    = 4'hF;
        tick(1);
        sys_rst   = 1'b0;
        mem_we    = '0;
        check("mid_rst_status", 64'(status), 64'd0);
        check("mid_rst_fail", 64'(fail_code), 64'd0);
        check("mid_rst_cnt", 64'(cycle_count), 64'd0);
        check("mid_rst_valid", 64'(con_valid), 64'd0);
        check("mid_rst_data", 64'(con_data), 64'd0);
        tick(1);
        do_write(32'h1000, 32'd0, 4'h1);
        check("zero_fail_status", 64'(status), 64'd2);
        check("zero_fail_code", 64'(fail_code), 64'd0);

        // Random traffic.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            sys_rst   = (r < 2) || (done && $urandom_range(0, 9) == 0);
            mem_we    = 4'($urandom_range(0, 15));
            mem_wdata = $urandom;
            con_ready = ($urandom_range(0, 2) != 0);
            if (r < 6) begin
                mem_addr = 32'h1000;
                if ($urandom_range(0, 1) == 1) mem_wdata = 32'd1;
            end else if (r < 60) begin
                mem_addr = 32'h1004;
            end else begin
                mem_addr = 32'h8000 + 32'($urandom_range(0, 255)) * 8;
            end
            tick(1);
        end
        sys_rst   = 1'b0;
        mem_we    = '0;
        con_ready = 1'b0;
        tick(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
